// File: rtl/ssd1306_spi_sink_pkg.sv
// Shared opcodes, command-FSM states and argument-count lookup for the
// SSD1306 serial-stream sink.
package ssd1306_pkg;

  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2
  } cmd_state_e;

  // Number of argument bytes that follow an opcode; unknown opcodes take none.
  function automatic logic [1:0] cmd_arg_count(input logic [7:0] op);
    logic [1:0] n;
    case (op)
      CMD_COL_ADDR, CMD_PAGE_ADDR: n = 2'd2;
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:  n = 2'd1;
      default:                     n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_if.sv
// 4-wire SSD1306 serial bus: the OLED driver is master, the sink is slave.
interface ssd1306_spi_sink_if;

  logic sclk;
  logic mosi;
  logic cs_n;
  logic dc;

  modport master (output sclk, output mosi, output cs_n, output dc);
  modport slave  (input  sclk, input  mosi, input  cs_n, input  dc);

endinterface

// File: rtl/ssd1306_spi_sink_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronizes the bus into clk,
// detects SCLK rising edges and assembles MSB-first bytes.
module spi_byte_rx (
  input  logic                     clk,
  input  logic                     rst_n,
  ssd1306_spi_sink_if.slave        spi,
  output logic                     byte_valid,
  output logic [7:0]               byte_data,
  output logic                     byte_is_cmd
);

  logic [1:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] dc_sync_q;
  logic       sclk_prev_q;
  logic       rise_q;
  logic       mosi_bit_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_is_cmd_q, byte_is_cmd_d;

  // Edge detect is registered together with its data bit so the shift stage
  // sees a stable (edge, bit) pair; chip-select is applied at the shift stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      mosi_bit_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
      cs_sync_q   <= {cs_sync_q[0], spi.cs_n};
      dc_sync_q   <= {dc_sync_q[0], spi.dc};
      sclk_prev_q <= sclk_sync_q[1];
      rise_q      <= sclk_sync_q[1] & ~sclk_prev_q;
      mosi_bit_q  <= mosi_sync_q[1];
    end
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    byte_is_cmd_d = byte_is_cmd_q;
    if (cs_sync_q[1]) begin
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
    end else if (rise_q) begin
      shift_d = {shift_q[6:0], mosi_bit_q};
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d     = 3'd0;
        byte_valid_d  = 1'b1;
        byte_data_d   = shift_d;
        byte_is_cmd_d = ~dc_sync_q[1];
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'h00;
      byte_is_cmd_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      byte_is_cmd_q <= byte_is_cmd_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_is_cmd = byte_is_cmd_q;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 display-side sink: decodes addressing/display commands and turns
// data bytes into (column, page, data) pixel writes.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ssd1306_spi_sink_if.slave          spi,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic                       byte_is_cmd,
  output logic                       pix_we,
  output logic [$clog2(COLS)-1:0]    pix_col,
  output logic [$clog2(PAGES)-1:0]   pix_page,
  output logic [7:0]                 pix_data,
  output logic                       display_on,
  output logic                       frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = $clog2(PAGES);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_is_cmd;

  spi_byte_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi),
    .byte_valid  (rx_valid),
    .byte_data   (rx_data),
    .byte_is_cmd (rx_is_cmd)
  );

  cmd_state_e        state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [COL_W-1:0]  arg1_q, arg1_d;
  logic [COL_W-1:0]  col_start_q, col_start_d;
  logic [COL_W-1:0]  col_end_q, col_end_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PAGE_W-1:0] page_start_q, page_start_d;
  logic [PAGE_W-1:0] page_end_q, page_end_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              display_on_q, display_on_d;
  logic              frame_done_q, frame_done_d;

  // The first window argument is held aside and only committed with the
  // second, so an aborted sequence leaves the window untouched.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg1_d       = arg1_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    display_on_d = display_on_q;
    frame_done_d = 1'b0;

    if (rx_valid) begin
      if (rx_is_cmd) begin
        case (state_q)
          ST_IDLE: begin
            op_d = rx_data;
            if (rx_data == CMD_DISP_OFF) display_on_d = 1'b0;
            if (rx_data == CMD_DISP_ON)  display_on_d = 1'b1;
            case (cmd_arg_count(rx_data))
              2'd2:    state_d = ST_ARG1;
              2'd1:    state_d = ST_ARG2;
              default: state_d = ST_IDLE;
            endcase
          end
          ST_ARG1: begin
            arg1_d  = rx_data[COL_W-1:0];
            state_d = ST_ARG2;
          end
          ST_ARG2: begin
            state_d = ST_IDLE;
            if (op_q == CMD_COL_ADDR) begin
              col_start_d = arg1_q;
              col_end_d   = rx_data[COL_W-1:0];
              col_d       = arg1_q;
            end else if (op_q == CMD_PAGE_ADDR) begin
              page_start_d = arg1_q[PAGE_W-1:0];
              page_end_d   = rx_data[PAGE_W-1:0];
              page_d       = arg1_q[PAGE_W-1:0];
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end else begin
        state_d = ST_IDLE;
        if (col_q == col_end_q) begin
          col_d = col_start_q;
          if (page_q == page_end_q) begin
            page_d       = page_start_q;
            frame_done_d = 1'b1;
          end else begin
            page_d = page_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 8'h00;
      arg1_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_W'(COLS - 1);
      col_q        <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_W'(PAGES - 1);
      page_q       <= '0;
      display_on_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg1_q       <= arg1_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      display_on_q <= display_on_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The write reports the address before this byte advances it.
  assign byte_valid  = rx_valid;
  assign byte_data   = rx_data;
  assign byte_is_cmd = rx_is_cmd;
  assign pix_we      = rx_valid & ~rx_is_cmd;
  assign pix_col     = col_q;
  assign pix_page    = page_q;
  assign pix_data    = rx_data;
  assign display_on  = display_on_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Scoreboard bench for ssd1306_spi_sink: directed scenarios plus random
// command/data traffic checked against a byte-level display model.
module tb_ssd1306_spi_sink;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_is_cmd;
   logic       pix_we;
   logic [6:0] pix_col;
   logic [2:0] pix_page;
   logic [7:0] pix_data;
   logic       display_on;
   logic       frame_done;

   ssd1306_spi_sink_if spi_bus ();

   ssd1306_spi_sink #(.COLS(128), .PAGES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi         (spi_bus),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_is_cmd (byte_is_cmd),
      .pix_we      (pix_we),
      .pix_col     (pix_col),
      .pix_page    (pix_page),
      .pix_data    (pix_data),
      .display_on  (display_on),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // Counts rising clock edges so the monitor can time each byte strobe.
   longint cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      bit         is_cmd;
      bit         we;
      int         col;
      int         page;
      bit         frame;
      bit         disp;
      longint     cyc;
   } exp_t;

   exp_t exp_q[$];

   // Display model: window, cursor, display flag and an opcode-plus-arguments buffer.
   int         m_cs, m_ce, m_ps, m_pe, m_col, m_page;
   bit         m_disp;
   logic [7:0] cmd_buf[$];
   int         frames_seen = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   function automatic int nargs(input logic [7:0] op);
      case (op)
         8'h21, 8'h22: return 2;
         8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic modelReset();
      m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
      m_col = 0; m_page = 0; m_disp = 0;
      cmd_buf.delete();
      exp_q.delete();
   endtask

   // Predicts what one received byte does to the display.
   task automatic modelByte(input logic [7:0] b, input bit is_data, output exp_t e);
      e.data = b; e.is_cmd = !is_data; e.we = is_data;
      e.col = 0; e.page = 0; e.frame = 0; e.cyc = 0;
      if (is_data) begin
         cmd_buf.delete();
         e.col = m_col; e.page = m_page;
         if (m_col == m_ce) begin
            m_col = m_cs;
            if (m_page == m_pe) begin
               m_page = m_ps;
               e.frame = 1;
            end else begin
               m_page = (m_page + 1) % 8;
            end
         end else begin
            m_col = (m_col + 1) % 128;
         end
      end else if (cmd_buf.size() == 0) begin
         if (b == 8'hAE) m_disp = 0;
         else if (b == 8'hAF) m_disp = 1;
         else if (nargs(b) > 0) cmd_buf.push_back(b);
      end else begin
         cmd_buf.push_back(b);
         if (cmd_buf.size() == 1 + nargs(cmd_buf[0])) begin
            if (cmd_buf[0] == 8'h21) begin
               m_cs = int'(cmd_buf[1]) & 127; m_ce = int'(cmd_buf[2]) & 127; m_col = m_cs;
            end else if (cmd_buf[0] == 8'h22) begin
               m_ps = int'(cmd_buf[1]) & 7; m_pe = int'(cmd_buf[2]) & 7; m_page = m_ps;
            end
            cmd_buf.delete();
         end
      end
      e.disp = m_disp;
   endtask

   // Shifts one byte out in SPI mode 0; the expectation is queued at the 8th rising edge.
   task automatic applyStimulus(input logic [7:0] b, input bit is_data, input int half);
      exp_t e;
      spi_bus.cs_n = 1'b0;
      spi_bus.dc   = is_data;
      for (int i = 7; i >= 0; i--) begin
         spi_bus.mosi = b[i];
         repeat (half) @(negedge clk);
         spi_bus.sclk = 1'b1;
         if (i == 0) begin
            modelByte(b, is_data, e);
            e.cyc = cyc + 4;
            exp_q.push_back(e);
         end
         repeat (half) @(negedge clk);
         spi_bus.sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic csPulse();
      spi_bus.cs_n = 1'b1;
      repeat (6) @(negedge clk);
      spi_bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic partialBits(input int n, input int half);
      spi_bus.cs_n = 1'b0;
      spi_bus.dc   = 1'b1;
      for (int i = 0; i < n; i++) begin
         spi_bus.mosi = 1'($urandom_range(0, 1));
         repeat (half) @(negedge clk);
         spi_bus.sclk = 1'b1;
         repeat (half) @(negedge clk);
         spi_bus.sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
      csPulse();
   endtask

   task automatic doReset();
      spi_bus.sclk = 1'b0;
      spi_bus.cs_n = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      modelReset();
      rst_n = 1'b1;
      spi_bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Monitor: pops one expectation per byte strobe; frame_done and display_on
   // are checked on the cycle after the byte that should change them.
   bit exp_fd = 0;
   bit disp_pend = 0;
   bit disp_val = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_fd = 0;
         disp_pend = 0;
      end else begin
         if (frame_done) frames_seen++;
         if (frame_done || exp_fd) checkOutput("frame_done", frame_done, exp_fd);
         exp_fd = 0;
         if (disp_pend) begin
            checkOutput("display_on", display_on, disp_val);
            disp_pend = 0;
         end
         if (pix_we && !byte_valid) checkOutput("pix_we_without_byte", pix_we, byte_valid);
         if (byte_valid) begin
            checkOutput("byte_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("byte_data", byte_data, e.data);
               checkOutput("byte_is_cmd", byte_is_cmd, e.is_cmd);
               checkOutput("byte_latency_cycle", cyc, e.cyc);
               checkOutput("pix_we", pix_we, e.we);
               if (e.we) begin
                  checkOutput("pix_col", pix_col, e.col);
                  checkOutput("pix_page", pix_page, e.page);
                  checkOutput("pix_data", pix_data, e.data);
               end
               exp_fd    = e.frame;
               disp_pend = 1;
               disp_val  = e.disp;
            end
         end
      end
   end

   logic [7:0] one_arg [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

   initial begin
      int f0;
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = 1'b0;
      spi_bus.cs_n = 1'b1;
      spi_bus.dc   = 1'b0;
      modelReset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_byte_valid", byte_valid, 0);
      checkOutput("reset_byte_data", byte_data, 0);
      checkOutput("reset_byte_is_cmd", byte_is_cmd, 0);
      checkOutput("reset_pix_we", pix_we, 0);
      checkOutput("reset_pix_col", pix_col, 0);
      checkOutput("reset_pix_page", pix_page, 0);
      checkOutput("reset_display_on", display_on, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      rst_n = 1'b1;
      spi_bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] first data byte at SCLK = clk/8");
      applyStimulus(8'hA5, 1, 4);

      $display("[TB] display on/off commands");
      applyStimulus(8'hAF, 0, 4);
      applyStimulus(8'hAE, 0, 4);

      $display("[TB] 2x2 window with frame wrap");
      applyStimulus(8'h21, 0, 4); applyStimulus(8'h10, 0, 4); applyStimulus(8'h11, 0, 4);
      applyStimulus(8'h22, 0, 4); csPulse();
      applyStimulus(8'h06, 0, 4); applyStimulus(8'h07, 0, 4);
      for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(0, 255)), 1, 4);

      $display("[TB] partial byte discarded by CS");
      partialBits(5, 4);
      applyStimulus(8'h3C, 1, 4);

      $display("[TB] window sequence aborted by data");
      applyStimulus(8'h21, 0, 4); applyStimulus(8'h20, 0, 4);
      applyStimulus(8'h55, 1, 4);
      applyStimulus(8'h66, 1, 4);

      $display("[TB] random traffic");
      for (int n = 0; n < 120; n++) begin
         int k;
         int h;
         k = $urandom_range(0, 9);
         h = $urandom_range(2, 4);
         case (k)
            5, 6: begin
               applyStimulus((k == 5) ? 8'h21 : 8'h22, 0, h);
               if ($urandom_range(0, 3) == 0) csPulse();
               applyStimulus(8'($urandom_range(0, 255)), 0, h);
               applyStimulus(8'($urandom_range(0, 255)), 0, h);
            end
            7: applyStimulus(($urandom_range(0, 1) == 1) ? 8'hAF : 8'hAE, 0, h);
            8: begin
               applyStimulus(one_arg[$urandom_range(0, 8)], 0, h);
               applyStimulus(8'($urandom_range(0, 255)), 0, h);
            end
            9: applyStimulus(8'($urandom_range(0, 255)), 0, h);
            default: applyStimulus(8'($urandom_range(0, 255)), 1, h);
         endcase
         if ($urandom_range(0, 7) == 0) csPulse();
      end

      repeat (10) @(negedge clk);
      checkOutput("queue_drained_before_sweep", exp_q.size(), 0);

      $display("[TB] full-frame sweep with default window");
      doReset();
      f0 = frames_seen;
      for (int i = 0; i < 1025; i++) applyStimulus(8'($urandom_range(0, 255)), 1, 2);
      repeat (10) @(negedge clk);
      checkOutput("sweep_frame_count", frames_seen - f0, 1);
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
